// File: rtl/demux_lane_sched_pkg.sv
`timescale 1ns/1ps
// demux_pkg: shared types and constants for the demux_lane_sched scheduler.
//   state_t  : scheduler FSM state (IDLE / RUN)
//   LANE0/1  : lane select encodings
//   MODE_RR  : round-robin steering, skipping a stalled lane
//   MODE_KEY : steering by the LSB of the incoming word
package demux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic LANE0    = 1'b0;
    localparam logic LANE1    = 1'b1;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_KEY = 1'b1;

endpackage

// File: rtl/demux_lane_sched_if.sv
`timescale 1ns/1ps
// demux_lane_sched_if: bundles the source handshake, lane stall inputs, lane
// outputs and status of the 1-to-2 demux scheduler.
//   master : the word source / consumer side (drives en, mode, valid_in,
//            data_in, full0, full1)
//   slave  : the scheduler (drives ready_in, lane outputs, ptr, counters)
interface demux_lane_sched_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic              en;
    logic              mode;
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              ready_in;
    logic              full0;
    logic              full1;
    logic              valid_out0;
    logic [DATA_W-1:0] data_out0;
    logic              valid_out1;
    logic [DATA_W-1:0] data_out1;
    logic              ptr;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    modport master (
        output en, mode, valid_in, data_in, full0, full1,
        input  ready_in, valid_out0, data_out0, valid_out1, data_out1,
               ptr, cnt0, cnt1
    );

    modport slave (
        input  en, mode, valid_in, data_in, full0, full1,
        output ready_in, valid_out0, data_out0, valid_out1, data_out1,
               ptr, cnt0, cnt1
    );
endinterface

// File: rtl/demux_lane_sched_lane_reg.sv
`timescale 1ns/1ps
// demux_lane_reg: output register for one demux lane plus its wrapping
// delivered-word counter.
//   clk, reset : clock and synchronous active-high reset
//   load       : word accepted for this lane this cycle
//   d          : word to capture
//   valid_out  : one-cycle pulse following each load
//   data_out   : last delivered word, held between deliveries
//   cnt        : words delivered, wraps to 0 with no flag
module demux_lane_reg #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            cnt       <= '0;
        end else begin
            valid_out <= load;
            if (load) begin
                data_out <= d;
                cnt      <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_lane_sched.sv
`timescale 1ns/1ps
// demux_lane_sched: steers a valid/ready word stream to one of two lanes,
// either round-robin (skipping a stalled lane) or keyed by the word LSB.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of demux_lane_sched_if (en, mode, valid_in,
//                data_in, full0/1 in; ready_in, valid_out0/1, data_out0/1,
//                ptr, cnt0/1 out)
// ready_in and the target lane are combinational so lane stalls take effect
// in the same cycle; lane outputs are registered with one cycle of latency.
module demux_lane_sched
    import demux_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    demux_lane_sched_if.slave     bus
);

    state_t r_state;
    logic   r_mode_q;
    logic   r_ptr;

    logic   w_run;
    logic   w_tgt;
    logic   w_ready;
    logic   w_accept;
    logic   w_load0;
    logic   w_load1;

    assign w_run = (r_state == ST_RUN);

    always_comb begin
        w_tgt   = r_ptr;
        w_ready = 1'b0;
        if (r_mode_q == MODE_KEY) begin
            w_tgt   = bus.data_in[0];
            w_ready = w_run & !(w_tgt ? bus.full1 : bus.full0);
        end else begin
            // Preferred lane stalled: fall back to the other one.
            w_tgt   = (r_ptr ? bus.full1 : bus.full0) ? ~r_ptr : r_ptr;
            w_ready = w_run & !(bus.full0 & bus.full1);
        end
    end

    assign w_accept     = bus.valid_in & w_ready;
    assign w_load0      = w_accept & (w_tgt == LANE0);
    assign w_load1      = w_accept & (w_tgt == LANE1);
    assign bus.ready_in = w_ready;
    assign bus.ptr      = r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mode_q <= MODE_RR;
            r_ptr    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.en) begin
                        r_state  <= ST_RUN;
                        r_mode_q <= bus.mode;
                    end
                end
                ST_RUN: begin
                    if (!bus.en) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // After a skip the stalled lane becomes the preferred one.
            if (w_accept && (r_mode_q == MODE_RR)) begin
                r_ptr <= ~w_tgt;
            end
        end
    end

    demux_lane_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_lane0 (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load0),
        .d         (bus.data_in),
        .valid_out (bus.valid_out0),
        .data_out  (bus.data_out0),
        .cnt       (bus.cnt0)
    );

    demux_lane_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_lane1 (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load1),
        .d         (bus.data_in),
        .valid_out (bus.valid_out1),
        .data_out  (bus.data_out1),
        .cnt       (bus.cnt1)
    );

endmodule
